// File: rtl/uart_pkg.sv
// Shared UART arbiter types and frame constants.
package uart_pkg;

  localparam int unsigned UART_FRAME_BITS   = 10;
  localparam int unsigned UART_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and transmitter-side signals of the UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid_i;
  logic [8*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic [7:0]         tx_data_o;
  logic               tx_start_o;
  logic               busy_o;
  logic [ID_W-1:0]    grant_id_o;
  logic               done_o;

  modport master (
    output req_valid_i, req_data_i,
    input  req_ready_o, tx_data_o, tx_start_o, busy_o, grant_id_o, done_o
  );

  modport slave (
    input  req_valid_i, req_data_i,
    output req_ready_o, tx_data_o, tx_start_o, busy_o, grant_id_o, done_o
  );
endinterface

// File: rtl/uart_rr_picker.sv
// Combinational one-hot winner selection: round-robin after last_i by default,
// lowest-index fixed priority when UART_ARB_FIXED_PRIO_EN is defined.
module uart_rr_picker #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid_i,
`ifndef UART_ARB_FIXED_PRIO_EN
  input  logic [$clog2(N_REQ)-1:0] last_i,
`endif
  output logic                     any_o,
  output logic [N_REQ-1:0]         win_oh_o,
  output logic [$clog2(N_REQ)-1:0] win_id_o
);
  localparam int unsigned ID_W = $clog2(N_REQ);

`ifdef UART_ARB_FIXED_PRIO_EN
  // Scan high to low so the lowest valid index is the last one written.
  always_comb begin
    any_o    = |valid_i;
    win_oh_o = '0;
    win_id_o = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (valid_i[ID_W'(i)]) begin
        win_oh_o             = '0;
        win_oh_o[ID_W'(i)]   = 1'b1;
        win_id_o             = ID_W'(i);
      end
    end
  end
`else
  // Scan farthest to nearest from last_i+1 so the nearest valid index wins.
  always_comb begin
    int idx;
    any_o    = |valid_i;
    win_oh_o = '0;
    win_id_o = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      idx = (int'(last_i) + k) % int'(N_REQ);
      if (valid_i[ID_W'(idx)]) begin
        win_oh_o             = '0;
        win_oh_o[ID_W'(idx)] = 1'b1;
        win_id_o             = ID_W'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers and times each frame.
// Arbitration is round-robin unless UART_ARB_FIXED_PRIO_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FRAME_BITS   = UART_FRAME_BITS
) (
  input logic              clk_i,
  input logic              rstb_i,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned ID_W         = $clog2(N_REQ);
  localparam int unsigned FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
  localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             tx_start_q, tx_start_d;
  logic             done_q, done_d;
  logic [N_REQ-1:0] ready_c;

  logic             any_c;
  logic [N_REQ-1:0] win_oh_c;
  logic [ID_W-1:0]  win_id_c;

`ifndef UART_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]  last_q, last_d;
`endif

  uart_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .valid_i  (bus.req_valid_i),
`ifndef UART_ARB_FIXED_PRIO_EN
    .last_i   (last_q),
`endif
    .any_o    (any_c),
    .win_oh_o (win_oh_c),
    .win_id_o (win_id_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    ready_c    = '0;
`ifndef UART_ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          ready_c    = win_oh_c;
          tx_data_d  = 8'(bus.req_data_i >> (8 * win_id_c));
          grant_d    = win_id_c;
          busy_d     = 1'b1;
          tx_start_d = 1'b1;
          state_d    = ST_START;
`ifndef UART_ARB_FIXED_PRIO_EN
          last_d     = win_id_c;
`endif
        end
      end
      ST_START: begin
        cnt_d   = CNT_W'(FRAME_CYCLES - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        // done is registered, so it is raised one count early to land on cnt==0.
        if (cnt_q == CNT_W'(1)) done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
    end
  end

`ifndef UART_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) last_q <= ID_W'(N_REQ - 1);
    else         last_q <= last_d;
  end
`endif

  // Ready is forced low while reset is held so no byte is acknowledged in reset.
  assign bus.req_ready_o = ready_c & {N_REQ{rstb_i}};
  assign bus.tx_data_o   = tx_data_q;
  assign bus.tx_start_o  = tx_start_q;
  assign bus.busy_o      = busy_q;
  assign bus.grant_id_o  = grant_q;
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a serial transmitter/receiver loopback model.
module tb_uart_tx_arbiter;
  localparam int unsigned NR  = 4;
  localparam int unsigned CPB = 4;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(NR)) bus ();

  uart_tx_arbiter #(.N_REQ(NR), .CLKS_PER_BIT(CPB), .FRAME_BITS(10)) dut (
    .clk_i  (clk),
    .rstb_i (rstb),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Serial line model of the downstream transmitter, LSB first, 4 clocks per bit.
  logic       line    = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  int         rx_cnt  = 0;

  always begin : tx_model
    logic [9:0] fr;
    @(negedge clk);
    if (rstb && bus.tx_start_o) begin
      fr = {1'b1, bus.tx_data_o, 1'b0};
      for (int b = 0; b < 10; b++) begin
        line = fr[b];
        repeat (CPB) @(negedge clk);
      end
    end
  end

  always begin : rx_model
    logic [7:0] r;
    @(negedge line);
    repeat (CPB / 2) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      repeat (CPB) @(negedge clk);
      r[b] = line;
    end
    repeat (CPB) @(negedge clk);
    rx_byte = r;
    rx_cnt++;
  end

  task automatic set_req(input logic [3:0] v, input logic [31:0] d);
    bus.req_valid_i = v;
    bus.req_data_i  = d;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w, c, t, t_prev, bad, starts, rx0, exp_id;

    set_req(4'h0, 32'h0);
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_ready",    32'(bus.req_ready_o), 32'd0);
    chk("por_busy",     32'(bus.busy_o),      32'd0);
    chk("por_tx_start", 32'(bus.tx_start_o),  32'd0);
    chk("por_done",     32'(bus.done_o),      32'd0);
    chk("por_tx_data",  32'(bus.tx_data_o),   32'd0);
    chk("por_grant",    32'(bus.grant_id_o),  32'd0);
    rstb = 1'b1;
    @(negedge clk);

    // Round-robin with all four requesters continuously valid.
    set_req(4'hF, 32'h13121110);
    #1;
    chk("rr_ready_first", 32'(bus.req_ready_o), 32'd1);
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (!bus.tx_start_o && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("rr_start_timeout", 32'(w < 100), 32'd1);
      t = cyc;
`ifdef UART_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = k % 4;
`endif
      chk("rr_grant",   32'(bus.grant_id_o), 32'(exp_id));
      chk("rr_tx_data", 32'(bus.tx_data_o),  32'(8'h10 + exp_id));
      if (k > 0) chk("rr_spacing", 32'(t - t_prev), 32'd42);
      t_prev = t;
      @(negedge clk);
    end
    set_req(4'h0, 32'h0);
    wait_idle();

    // Single request: timing and loopback.
    rx0 = rx_cnt;
    set_req(4'b0010, 32'h0000A500);
    #1;
    chk("single_ready", 32'(bus.req_ready_o), 32'h2);
    @(negedge clk);
    set_req(4'h0, 32'h0);
    chk("single_tx_start", 32'(bus.tx_start_o), 32'd1);
    chk("single_tx_data",  32'(bus.tx_data_o),  32'hA5);
    chk("single_grant",    32'(bus.grant_id_o), 32'd1);
    chk("single_busy",     32'(bus.busy_o),     32'd1);
    c = 1;
    while (!bus.done_o && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("single_done_cycle", 32'(c), 32'd41);
    @(negedge clk);
    chk("single_busy_low", 32'(bus.busy_o), 32'd0);
    chk("single_done_low", 32'(bus.done_o), 32'd0);
    w = 0;
    while (rx_cnt == rx0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("loopback_byte", 32'(rx_byte), 32'hA5);

    // Request raised during WAIT is held off until IDLE.
    set_req(4'b0010, 32'h00003300);
    @(negedge clk);
    set_req(4'h0, 32'h0);
    repeat (5) @(negedge clk);
    set_req(4'b1000, 32'hC3000000);
    w = 0;
    bad = 0;
    #1;
    while (!bus.done_o && w < 200) begin
      if (|bus.req_ready_o) bad++;
      @(negedge clk);
      #1;
      w++;
    end
    chk("wait_ready_leak",     32'(bad),             32'd0);
    chk("wait_done_seen",      32'(bus.done_o),      32'd1);
    chk("ready_on_done_cycle", 32'(bus.req_ready_o), 32'd0);
    @(negedge clk);
    #1;
    chk("ready_after_done", 32'(bus.req_ready_o), 32'h8);
    chk("idle_busy_low",    32'(bus.busy_o),      32'd0);
    @(negedge clk);
    set_req(4'h0, 32'h0);
    chk("late_tx_start", 32'(bus.tx_start_o), 32'd1);
    chk("late_grant",    32'(bus.grant_id_o), 32'd3);
    chk("late_tx_data",  32'(bus.tx_data_o),  32'hC3);
    wait_idle();

    // Valid pulsed and withdrawn during WAIT is never served.
    set_req(4'b0010, 32'h00004400);
    @(negedge clk);
    set_req(4'h0, 32'h0);
    repeat (5) @(negedge clk);
    set_req(4'b0001, 32'h00000077);
    #1;
    chk("withdrawn_ready", 32'(bus.req_ready_o), 32'd0);
    @(negedge clk);
    set_req(4'h0, 32'h0);
    wait_idle();
    starts = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.tx_start_o) starts++;
    end
    chk("withdrawn_no_start", 32'(starts),         32'd0);
    chk("grant_held",         32'(bus.grant_id_o), 32'd1);
    chk("data_held",          32'(bus.tx_data_o),  32'h44);

    // Reset mid-WAIT, then requester 2 is served straight after release.
    set_req(4'b0010, 32'h00006600);
    @(negedge clk);
    set_req(4'h0, 32'h0);
    repeat (10) @(negedge clk);
    set_req(4'b0100, 32'h005A0000);
    rstb = 1'b0;
    #1;
    chk("rst_ready",    32'(bus.req_ready_o), 32'd0);
    chk("rst_busy",     32'(bus.busy_o),      32'd0);
    chk("rst_tx_start", 32'(bus.tx_start_o),  32'd0);
    chk("rst_done",     32'(bus.done_o),      32'd0);
    chk("rst_tx_data",  32'(bus.tx_data_o),   32'd0);
    chk("rst_grant",    32'(bus.grant_id_o),  32'd0);
    @(negedge clk);
    rstb = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready_o), 32'h4);
    @(negedge clk);
    set_req(4'h0, 32'h0);
    chk("post_rst_tx_start", 32'(bus.tx_start_o), 32'd1);
    chk("post_rst_tx_data",  32'(bus.tx_data_o),  32'h5A);
    chk("post_rst_grant",    32'(bus.grant_id_o), 32'd2);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between `N_REQ` byte producers.
- Picks one pending requester and accepts its byte with a valid/ready handshake.
- Issues a one-cycle start pulse with stable data to the transmitter.
- Times the frame internally, because the transmitter exposes no busy flag, and waits for it to finish before accepting the next byte.

It sits between on-chip producers and the existing UART transmitter, in the same clock and reset domain.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters, 2..8.
- `CLKS_PER_BIT`, 868 — clock cycles per UART bit. 868 = 100 MHz / 115200; must match the transmitter.
- `FRAME_BITS`, 10 — bits per frame (start + 8 data + stop).

Ports:
- `clk_i` in, 1 — single clock, rising edge.
- `rstb_i` in, 1 — reset, asynchronous, active-low.
- `req_valid_i` in, `N_REQ` — requester i has a byte pending.
- `req_data_i` in, `8*N_REQ` — byte of requester i at bits [8i+7:8i].
- `req_ready_o` out, `N_REQ` — one-hot, one-cycle accept. A byte transfers when valid&ready.
- `tx_data_o` out, 8 — byte to the transmitter's `data_i`.
- `tx_start_o` out, 1 — one-cycle pulse to the transmitter's `tx_start`.
- `busy_o` out, 1 — high from accept until the frame time expires.
- `grant_id_o` out, `$clog2(N_REQ)` — index of the requester being served.
- `done_o` out, 1 — one-cycle pulse when the frame time expires.

## Operation
- `FRAME_CYCLES` = `CLKS_PER_BIT*FRAME_BITS`. The down-counter is `$clog2(FRAME_CYCLES)` bits wide and unsigned.
- FSM states: IDLE, START, WAIT.
- **IDLE:** if any `req_valid_i` is high, the winner w gets `req_ready_o[w]`=1 in that same cycle.
  - `req_data_i[w]` is registered into `tx_data_o` and w into `grant_id_o`.
  - `busy_o` is set and the FSM goes to START.
  - If no requester is valid, the FSM stays in IDLE and all `req_ready_o` are 0.
- **START:** `tx_start_o`=1 for exactly this cycle. The counter loads `FRAME_CYCLES-1` and the FSM goes to WAIT.
- **WAIT:** the counter decrements every cycle. When the counter is 0:
  - `done_o`=1;
  - `busy_o` clears on the next edge;
  - the FSM goes to IDLE.
- `tx_data_o` and `grant_id_o` hold from the accept until the next accept.
- Arbitration (default): round-robin.
  - Search starts at `last+1` mod `N_REQ`.
  - `last` updates only on an accept.
  - `last` resets to `N_REQ-1`, so requester 0 wins first.
- Requesters must hold valid and data until ready. Dropping valid before ready is tolerated: that requester is simply not picked.
- Valid inputs are ignored in START and WAIT. There is no queueing inside the block.
- Reset: asynchronous and immediate.
  - FSM goes to IDLE; counter 0; `last`=`N_REQ-1`.
  - All outputs 0: `req_ready_o`, `tx_data_o`, `tx_start_o`, `busy_o`, `grant_id_o`, `done_o`.
  - A reset mid-frame aborts the frame; the transmitter shares `rstb_i`. After release, arbitration restarts at requester 0.

## Timing
- Valid seen in IDLE at cycle 0 → ready at cycle 0, `tx_start_o` at cycle 1, `done_o` at cycle `FRAME_CYCLES`+1, IDLE at cycle `FRAME_CYCLES`+2.
- Back-to-back `tx_start_o` spacing with continuous requests is `FRAME_CYCLES`+2 cycles. This is at least one frame, so the transmitter never receives a start while busy.
- When `done_o` and a new request coincide, the request is accepted on the following cycle (IDLE). There is no bypass.
- `req_ready_o` is combinational from `req_valid_i` and state. All other outputs are registered.

## Configuration
- Macro `UART_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority; the lowest valid index always wins and `last` is not implemented.
- Undefined: round-robin as in Operation.
- The handshake and frame timing are identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE/START/WAIT);
  - `UART_FRAME_BITS`=10;
  - `UART_CLKS_PER_BIT` default 868.
- Sub-module `uart_rr_picker`: combinational one-hot winner from valid vector and `last` pointer. It contains the fixed-priority variant under the macro.
- The arbiter instantiates one picker; FSM and counter stay in the top.

## Test plan
Bench parameters: `CLKS_PER_BIT`=4, `N_REQ`=4, so `FRAME_CYCLES`=40.
- **Reset values:** assert `rstb_i`=0 mid-WAIT → all outputs 0 immediately. After release, valid[2] with 0x5A → ready[2] at once, `tx_start_o` next cycle, `tx_data_o`=0x5A.
- **Single request:** valid[1] with 0xA5 → `tx_start_o` 1 cycle later, `done_o` at cycle 41, `busy_o` low at cycle 42, transmitter loopback output = 0xA5.
- **Round-robin:** all four valid continuously, bytes 0x10..0x13 → grant order 0,1,2,3,0 and `tx_start_o` spacing exactly 42 cycles. With the macro defined, requester 0 always wins.
- **Ignored during WAIT:** valid[3] raised during WAIT → no ready until IDLE; accepted on the cycle after `done_o`.
- **Withdrawn request:** valid[0] pulsed for one cycle during WAIT, then dropped → never granted, no `tx_start_o`.
